// File: rtl/frame_capture.sv
// Captures one VGA frame and streams it as RGB565 pixels over Wishbone.
// Pixels pass through an input register stage (S1), a push register and a small write FIFO
// whose head drives single-beat Wishbone writes.
module frame_capture #(
  parameter int unsigned HDISP        = 640,
  parameter int unsigned VDISP        = 480,
  parameter int unsigned FIFO_DEPTH_W = 4
) (
  input  logic        vga_CLK,
  input  logic        rst,
  input  logic [7:0]  vid_R,
  input  logic [7:0]  vid_G,
  input  logic [7:0]  vid_B,
  input  logic        vid_HS,
  input  logic        vid_VS,
  input  logic        vid_BLANK,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [15:0] wb_dat_ms,
  output logic [1:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic        wb_ack,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned XW    = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned Depth = 1 << FIFO_DEPTH_W;
  localparam int unsigned CntW  = FIFO_DEPTH_W + 1;
  localparam logic [XW-1:0]   XLast   = XW'(HDISP - 1);
  localparam logic [YW-1:0]   YLast   = YW'(VDISP - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  typedef enum logic [1:0] {StWaitVs, StArmed, StCapture} state_e;

  state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic [7:0] s1_r, s1_g, s1_b;
  logic       s1_hs, s1_vs, s1_blank, vs_prev;
  logic       vs_fall, vs_rise;

  logic        pix_valid, done_d;
  logic [31:0] pix_lin, pix_adr;
  logic [15:0] pix_dat;

  logic        push_vld_q;
  logic [47:0] push_word_q;

  logic [47:0]             mem [Depth];
  logic [FIFO_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q, count_d;
  logic                    full, empty, do_push, do_pop;

  // HS and the colour LSBs are registered with the rest of S1 but carry no information we need.
  logic unused_s1;
  assign unused_s1 = ^{s1_hs, s1_r[2:0], s1_g[1:0], s1_b[2:0]};

  // S1: register the raw video inputs and keep last cycle's VS for edge detection.
  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_blank <= 1'b0;
      vs_prev  <= 1'b1;
    end else begin
      s1_r     <= vid_R;
      s1_g     <= vid_G;
      s1_b     <= vid_B;
      s1_hs    <= vid_HS;
      s1_vs    <= vid_VS;
      s1_blank <= vid_BLANK;
      vs_prev  <= s1_vs;
    end
  end

  assign vs_fall = vs_prev & ~s1_vs;
  assign vs_rise = ~vs_prev & s1_vs;

  // FSM state and pixel position registers.
  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      state_q <= StWaitVs;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Next-state: arm on VS fall, start on VS rise, count active pixels, abort on a new VS fall.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pix_valid = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StWaitVs: begin
        if (vs_fall) state_d = StArmed;
      end
      StArmed: begin
        if (vs_rise) begin
          state_d = StCapture;
          x_d     = '0;
          y_d     = '0;
        end
      end
      StCapture: begin
        if (vs_fall) begin
          state_d = StArmed;
        end else if (s1_blank) begin
          pix_valid = 1'b1;
          if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
              y_d     = '0;
              done_d  = 1'b1;
              state_d = StWaitVs;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: state_d = StWaitVs;
    endcase
  end

  // Byte address of the current pixel at full 32-bit width, and its RGB565 packing.
  always_comb begin
    pix_lin = 32'(y_q) * HDISP + 32'(x_q);
    pix_adr = pix_lin << 1;
    pix_dat = {s1_b[7:3], s1_g[7:2], s1_r[7:3]};
  end

  // Push register: holds the counted pixel for one cycle before it enters the FIFO.
  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      push_vld_q  <= 1'b0;
      push_word_q <= '0;
      frame_done  <= 1'b0;
    end else begin
      push_vld_q  <= pix_valid;
      push_word_q <= {pix_adr, pix_dat};
      frame_done  <= done_d;
    end
  end

  assign full    = (count_q == CntFull);
  assign empty   = (count_q == '0);
  // A full FIFO refuses the push even if the head pops in the same cycle.
  assign do_push = push_vld_q & ~full;
  assign do_pop  = wb_stb & wb_ack;

  // Occupancy bookkeeping; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_vld_q && full) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge vga_CLK) begin
    if (!rst && do_push) mem[wr_ptr_q] <= push_word_q;
  end

  // Wishbone master: one single-beat write per FIFO entry.
  always_comb begin
    wb_cyc    = ~empty;
    wb_stb    = ~empty;
    wb_we     = 1'b1;
    wb_sel    = 2'b11;
    wb_cti    = 3'b000;
    wb_bte    = 2'b00;
    wb_adr    = mem[rd_ptr_q][47:16];
    wb_dat_ms = mem[rd_ptr_q][15:0];
  end

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture: 640-pixel lines, 4-line frames.
module tb_frame_capture;

  localparam int unsigned HD = 640;
  localparam int unsigned VD = 4;

  logic        vga_CLK, rst;
  logic [7:0]  vid_R, vid_G, vid_B;
  logic        vid_HS, vid_VS, vid_BLANK;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_adr;
  logic [15:0] wb_dat_ms;
  logic [1:0]  wb_sel, wb_bte;
  logic [2:0]  wb_cti;
  logic        frame_done, overflow;

  int n_cmp = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  logic [47:0] wr_log[$];

  frame_capture #(.HDISP(HD), .VDISP(VD), .FIFO_DEPTH_W(4)) dut (
    .vga_CLK(vga_CLK), .rst(rst),
    .vid_R(vid_R), .vid_G(vid_G), .vid_B(vid_B),
    .vid_HS(vid_HS), .vid_VS(vid_VS), .vid_BLANK(vid_BLANK),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms),
    .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_ack(wb_ack), .frame_done(frame_done), .overflow(overflow)
  );

  initial vga_CLK = 1'b0;
  always #5 vga_CLK = ~vga_CLK;

  // Record every accepted write and every frame_done pulse, sampled mid-cycle.
  always @(negedge vga_CLK) begin
    if (wb_stb && wb_ack) wr_log.push_back({wb_adr, wb_dat_ms});
    if (frame_done) fd_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] colour(int x, int y);
    logic [7:0] r, g, b;
    if (x == 0 && y == 1) begin
      r = 8'hFF; g = 8'h00; b = 8'h00;
    end else begin
      r = 8'(x * 3);
      g = 8'(y * 37 + x);
      b = 8'(x ^ (y << 4));
    end
    return {r, g, b};
  endfunction

  function automatic logic [15:0] exp_dat(int x, int y);
    logic [23:0] c;
    c = colour(x, y);
    return {c[7:3], c[15:10], c[23:19]};
  endfunction

  task automatic step();
    @(posedge vga_CLK);
    #1;
  endtask

  task automatic vsync_pulse();
    vid_BLANK = 1'b0;
    vid_VS = 1'b0;
    repeat (3) step();
    vid_VS = 1'b1;
    repeat (3) step();
  endtask

  // n active pixels of line y, one blank cycle inserted before pixel 100, then blanking.
  task automatic line(int y, int n);
    logic [23:0] c;
    for (int x = 0; x < n; x++) begin
      if (x == 100) begin
        vid_BLANK = 1'b0;
        step();
      end
      c = colour(x, y);
      {vid_R, vid_G, vid_B} = c;
      vid_BLANK = 1'b1;
      step();
    end
    vid_BLANK = 1'b0;
    vid_HS = 1'b0;
    repeat (4) step();
    vid_HS = 1'b1;
    repeat (16) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++; if (wb_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", wb_stb); end
    n_cmp++; if (wb_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b want 0", wb_cyc); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++;
    if ({wb_we, wb_sel, wb_cti, wb_bte} !== 8'b1_11_000_00) begin
      n_fail++;
      $display("FAIL const_ctrl: got we=%b sel=%b cti=%b bte=%b want 1/11/000/00",
               wb_we, wb_sel, wb_cti, wb_bte);
    end
    rst = 1'b0;
    repeat (2) step();
    n_cmp++; if (wb_stb !== 1'b0) begin n_fail++; $display("FAIL idle_stb: got %b want 0", wb_stb); end
  endtask

  task automatic test_full_frame();
    int bad_adr, bad_dat, first_bad;
    logic [47:0] e;
    wb_ack = 1'b1;
    wr_log.delete();
    fd_cnt = 0;
    bad_adr = 0; bad_dat = 0; first_bad = -1;
    vsync_pulse();
    for (int y = 0; y <= int'(VD); y++) line(y, HD);  // last line falls after the frame ends
    n_cmp++;
    if (wr_log.size() != HD * VD) begin
      n_fail++; $display("FAIL frame_writes: got %0d want %0d", wr_log.size(), HD * VD);
    end
    for (int i = 0; i < wr_log.size() && i < int'(HD * VD); i++) begin
      e = wr_log[i];
      if (e[47:16] !== 32'(2 * i)) begin bad_adr++; if (first_bad < 0) first_bad = i; end
      if (e[15:0] !== exp_dat(i % HD, i / HD)) begin bad_dat++; if (first_bad < 0) first_bad = i; end
    end
    n_cmp++; if (bad_adr != 0) begin n_fail++; $display("FAIL frame_adr: got %0d bad (first %0d) want 0", bad_adr, first_bad); end
    n_cmp++; if (bad_dat != 0) begin n_fail++; $display("FAIL frame_dat: got %0d bad (first %0d) want 0", bad_dat, first_bad); end
    n_cmp++; if (wr_log[640] !== {32'd1280, 16'h001F}) begin n_fail++; $display("FAIL red_px: got %h want 00000500001f", wr_log[640]); end
    n_cmp++; if (wr_log[10] !== {32'd20, 16'h0843}) begin n_fail++; $display("FAIL px_10_0: got %h want 000000140843", wr_log[10]); end
    n_cmp++; if (wr_log[2120] !== {32'd4240, 16'hF9AB}) begin n_fail++; $display("FAIL px_200_3: got %h want 00001090f9ab", wr_log[2120]); end
    n_cmp++; if (fd_cnt != 1) begin n_fail++; $display("FAIL frame_done_cnt: got %0d want 1", fd_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL frame_ovf: got %b want 0", overflow); end
    n_cmp++; if (wb_stb !== 1'b0) begin n_fail++; $display("FAIL frame_drained: got %b want 0", wb_stb); end
  endtask

  task automatic test_latency();
    wb_ack = 1'b0;
    vsync_pulse();
    wr_log.delete();
    {vid_R, vid_G, vid_B} = {8'h00, 8'hFF, 8'h00};
    vid_BLANK = 1'b1;
    step();  // edge k
    vid_BLANK = 1'b0;
    n_cmp++; if (wb_stb !== 1'b0) begin n_fail++; $display("FAIL lat_k: got %b want 0", wb_stb); end
    step();
    n_cmp++; if (wb_stb !== 1'b0) begin n_fail++; $display("FAIL lat_k1: got %b want 0", wb_stb); end
    {vid_R, vid_G, vid_B} = {8'hFF, 8'h00, 8'h00};
    vid_BLANK = 1'b1;
    step();  // edge k+2
    vid_BLANK = 1'b0;
    n_cmp++;
    if (wb_stb !== 1'b1 || wb_adr !== 32'd0 || wb_dat_ms !== 16'h07E0) begin
      n_fail++; $display("FAIL lat_k2: got stb=%b adr=%h dat=%h want 1/0/07e0", wb_stb, wb_adr, wb_dat_ms);
    end
    repeat (4) step();
    n_cmp++;
    if (wb_adr !== 32'd0 || wb_dat_ms !== 16'h07E0) begin
      n_fail++; $display("FAIL head_hold: got adr=%h dat=%h want 0/07e0", wb_adr, wb_dat_ms);
    end
    for (int i = 0; i < 8; i++) begin
      wb_ack = i[0];
      step();
    end
    wb_ack = 1'b0;
    n_cmp++; if (wr_log.size() != 2) begin n_fail++; $display("FAIL alt_cnt: got %0d want 2", wr_log.size()); end
    n_cmp++; if (wr_log[0] !== {32'd0, 16'h07E0}) begin n_fail++; $display("FAIL alt_w0: got %h want 0000000007e0", wr_log[0]); end
    n_cmp++; if (wr_log[1] !== {32'd2, 16'h001F}) begin n_fail++; $display("FAIL alt_w1: got %h want 00000002001f", wr_log[1]); end
    n_cmp++; if (wb_stb !== 1'b0) begin n_fail++; $display("FAIL alt_empty: got %b want 0", wb_stb); end
  endtask

  task automatic test_overflow();
    wb_ack = 1'b0;
    vsync_pulse();
    wr_log.delete();
    line(0, HD);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_cmp++;
    if (wb_stb !== 1'b1 || wb_adr !== 32'd0) begin
      n_fail++; $display("FAIL ovf_head: got stb=%b adr=%h want 1/0", wb_stb, wb_adr);
    end
    wb_ack = 1'b1;
    repeat (30) step();
    n_cmp++; if (wr_log.size() != 16) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 16", wr_log.size()); end
    n_cmp++; if (wr_log[15][47:16] !== 32'd30) begin n_fail++; $display("FAIL ovf_last: got %0d want 30", wr_log[15][47:16]); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_abort();
    wb_ack = 1'b1;
    vsync_pulse();
    wr_log.delete();
    fd_cnt = 0;
    line(0, HD);
    line(1, HD);
    vsync_pulse();
    line(0, 5);
    n_cmp++; if (fd_cnt != 0) begin n_fail++; $display("FAIL abort_fd: got %0d want 0", fd_cnt); end
    n_cmp++; if (wr_log.size() != 1285) begin n_fail++; $display("FAIL abort_cnt: got %0d want 1285", wr_log.size()); end
    n_cmp++; if (wr_log[1279][47:16] !== 32'd2558) begin n_fail++; $display("FAIL abort_pre: got %0d want 2558", wr_log[1279][47:16]); end
    n_cmp++; if (wr_log[1280][47:16] !== 32'd0) begin n_fail++; $display("FAIL abort_restart: got %0d want 0", wr_log[1280][47:16]); end
    n_cmp++; if (wr_log[1284][47:16] !== 32'd8) begin n_fail++; $display("FAIL abort_px4: got %0d want 8", wr_log[1284][47:16]); end
  endtask

  task automatic test_reset_mid();
    wb_ack = 1'b0;
    vsync_pulse();
    vid_BLANK = 1'b1;
    repeat (5) step();
    vid_BLANK = 1'b0;
    repeat (4) step();
    n_cmp++; if (wb_stb !== 1'b1) begin n_fail++; $display("FAIL rm_pending: got %b want 1", wb_stb); end
    rst = 1'b1;
    step();
    n_cmp++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rm_stb: got stb=%b cyc=%b want 0/0", wb_stb, wb_cyc); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rm_ovf_clr: got %b want 0", overflow); end
    rst = 1'b0;
    wr_log.delete();
    wb_ack = 1'b1;
    vid_BLANK = 1'b1;
    repeat (10) step();
    vid_BLANK = 1'b0;
    repeat (5) step();
    n_cmp++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL rm_nowrite: got %0d want 0", wr_log.size()); end
    vsync_pulse();
    vid_BLANK = 1'b1;
    step();
    vid_BLANK = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (wr_log.size() != 1 || wr_log[0][47:16] !== 32'd0) begin
      n_fail++; $display("FAIL rm_resume: got cnt=%0d adr=%h want 1/0", wr_log.size(), wr_log[0][47:16]);
    end
  endtask

  initial begin
    rst = 1'b1;
    wb_ack = 1'b0;
    vid_R = '0; vid_G = '0; vid_B = '0;
    vid_HS = 1'b1; vid_VS = 1'b1; vid_BLANK = 1'b0;
    test_reset();
    test_full_frame();
    test_latency();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
